uart_tx_serializer: RTL and testbench



---
 rtl/uart_tx_serializer.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx_serializer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: pops bytes from uart_fifo, frames start/data(LSB first)/[parity]/stop on tx; optional parity via UART_TX_PARITY_EN.
// Latency: fifo_pop registered one cycle after an IDLE decision; tx falls the cycle after fifo_pop; tx_done on the last stop-bit cycle.
// Backpressure: no pop while enable=0 or fifo_empty=1; an in-flight frame always completes (only rst aborts it).
module uart_tx_serializer #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1,
    parameter int PARITY_ODD   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    output logic                  fifo_pop,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST  = CW'(DATA_WIDTH - 1);
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    if (CLKS_PER_BIT < 2 || (STOP_BITS != 1 && STOP_BITS != 2) ||
        PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
        $error("uart_tx_serializer: illegal parameter combination");
    end

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t                  state_q, state_d;
    logic [TW-1:0]           timer_q, timer_d;
    logic [CW-1:0]           dcnt_q, dcnt_d;
    logic                    scnt_q, scnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    fifo_pop_q, fifo_pop_d;
    logic                    tx_q, tx_d;
    logic                    busy_q, busy_d;
    logic                    tx_done_q, tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic                    par_q, par_d;
`endif

    logic bit_end;
    logic can_pop;

    assign bit_end = (timer_q == TIMER_LAST);
    assign can_pop = enable && !fifo_empty;

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        dcnt_d     = dcnt_q;
        scnt_d     = scnt_q;
        shift_d    = shift_q;
        fifo_pop_d = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        case (state_q)
            IDLE: begin
                timer_d = '0;
                // The pop strobe cycle itself is the single IDLE cycle between frames.
                if (fifo_pop_q) begin
                    state_d = START;
                end else if (can_pop) begin
                    fifo_pop_d = 1'b1;
                    shift_d    = fifo_data;
`ifdef UART_TX_PARITY_EN
                    par_d      = (^fifo_data) ^ PARITY_ODD[0];
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    timer_d = '0;
                    dcnt_d  = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (dcnt_q == DATA_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
                        scnt_d  = 1'b0;
`endif
                    end else begin
                        dcnt_d  = dcnt_q + 1'b1;
                        shift_d = shift_q >> 1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    timer_d = '0;
                    scnt_d  = 1'b0;
                    state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    timer_d = '0;
                    if (scnt_q == STOP_LAST) begin
                        // Look ahead so streaming frames are separated by exactly one IDLE cycle.
                        state_d = IDLE;
                        if (can_pop) begin
                            fifo_pop_d = 1'b1;
                            shift_d    = fifo_data;
`ifdef UART_TX_PARITY_EN
                            par_d      = (^fifo_data) ^ PARITY_ODD[0];
`endif
                        end
                    end else begin
                        scnt_d = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_q;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d    = (state_d != IDLE);
        tx_done_d = (state_d == STOP) && (timer_d == TIMER_LAST) && (scnt_d == STOP_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            dcnt_q     <= '0;
            scnt_q     <= 1'b0;
            shift_q    <= '0;
            fifo_pop_q <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            tx_done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            dcnt_q     <= dcnt_d;
            scnt_q     <= scnt_d;
            shift_q    <= shift_d;
            fifo_pop_q <= fifo_pop_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            tx_done_q  <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    assign fifo_pop = fifo_pop_q;
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed + randomized bench for uart_tx_serializer; expected tx waveform built from the frame format of each popped byte.
module tb_uart_tx_serializer;

    localparam int DW   = 8;
    localparam int CPB  = 16;
    localparam int SB   = 1;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int NBITS = 1 + DW + P + SB;
    localparam int FRAME = NBITS * CPB;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic [DW-1:0] fifo_data;
    logic          fifo_empty;
    logic          fifo_pop;
    logic          tx;
    logic          busy;
    logic          tx_done;

    int            vectors     = 0;
    int            miscompares = 0;
    int            cyc         = 0;
    byte unsigned  q[$];

    uart_tx_serializer #(
        .DATA_WIDTH  (DW),
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB),
        .PARITY_ODD  (PODD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .fifo_data (fifo_data),
        .fifo_empty(fifo_empty),
        .fifo_pop  (fifo_pop),
        .tx        (tx),
        .busy      (busy),
        .tx_done   (tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        fifo_empty = (q.size() == 0);
        fifo_data  = fifo_empty ? DW'($urandom) : q[0];
    endtask

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk({tag, " pop"},  fifo_pop, 0);
            chk({tag, " tx"},   tx,       1);
            chk({tag, " busy"}, busy,     0);
            chk({tag, " done"}, tx_done,  0);
        end
    endtask

    // Returns at the negedge of the pop cycle (or after the budget expires).
    task automatic wait_pop(input int budget, input string tag);
        bit seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (fifo_pop === 1'b1) seen = 1;
            else chk({tag, " idle tx"}, tx, 1);
        end
        chk({tag, " pop seen"}, seen, 1);
    endtask

    // Called at the negedge of a pop cycle; checks ncheck cycles of the frame.
    task automatic check_frame(input string tag, input int ncheck);
        byte unsigned b;
        logic         bits[$];
        if (q.size() == 0) begin
            chk({tag, " queue nonempty"}, 0, 1);
            b = 0;
        end else begin
            b = q.pop_front();
        end
        refresh();
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(((b >> i) & 1) != 0);
        if (P == 1) bits.push_back(((^b) ^ PODD[0]) != 0);
        for (int i = 0; i < SB; i++) bits.push_back(1'b1);
        for (int k = 0; k < ncheck; k++) begin
            @(negedge clk);
            chk($sformatf("%s k=%0d tx", tag, k),   tx,       bits[k / CPB]);
            chk($sformatf("%s k=%0d busy", tag, k), busy,     1);
            chk($sformatf("%s k=%0d done", tag, k), tx_done,  (k == FRAME - 1));
            chk($sformatf("%s k=%0d pop", tag, k),  fifo_pop, 0);
        end
    endtask

    initial begin
        int p0;
        rst    = 1'b1;
        enable = 1'b1;
        q.push_back(8'($urandom));
        refresh();

        // Reset held with data available: no activity.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset tx",   tx,       1);
            chk("reset busy", busy,     0);
            chk("reset pop",  fifo_pop, 0);
            chk("reset done", tx_done,  0);
        end
        rst = 1'b0;
        @(negedge clk);
        chk("first pop after reset", fifo_pop, 1);
        check_frame("rst_frame", FRAME);

        // Empty FIFO, enabled.
        idle_check(200, "empty");

        // Single byte.
        q.push_back(8'hA5);
        refresh();
        wait_pop(3, "a5");
        check_frame("a5", FRAME);
        idle_check(5, "after_a5");

        // Back-to-back 00 then FF.
        q.push_back(8'h00);
        q.push_back(8'hFF);
        refresh();
        wait_pop(3, "b2b");
        p0 = cyc;
        check_frame("b2b_00", FRAME);
        @(negedge clk);
        chk("b2b gap pop",  fifo_pop, 1);
        chk("b2b gap tx",   tx,       1);
        chk("b2b gap busy", busy,     0);
        chk("b2b pop period", cyc - p0, FRAME + 1);
        check_frame("b2b_ff", FRAME);
        idle_check(3, "after_b2b");

        // Reset during data bit 3 of 3C, then 81 with fresh timing.
        q.push_back(8'h3C);
        refresh();
        wait_pop(3, "3c");
        check_frame("3c_partial", CPB * 4 + CPB / 2);
        q.push_back(8'h81);
        refresh();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst tx",   tx,       1);
        chk("midrst busy", busy,     0);
        chk("midrst done", tx_done,  0);
        chk("midrst pop",  fifo_pop, 0);
        rst = 1'b0;
        wait_pop(3, "81");
        check_frame("81", FRAME);
        idle_check(3, "after_81");

        // Parity pattern byte (also plain framing when parity is off).
        q.push_back(8'h07);
        refresh();
        wait_pop(3, "07");
        check_frame("07", FRAME);

        // enable dropped mid-frame: frame completes, no further pop until re-enabled.
        q.push_back(8'($urandom));
        q.push_back(8'($urandom));
        refresh();
        wait_pop(3, "en");
        enable = 1'b0;
        check_frame("en_frame1", FRAME);
        idle_check(20, "en_off");
        enable = 1'b1;
        wait_pop(3, "en_on");
        check_frame("en_frame2", FRAME);

        // Randomized streaming burst.
        for (int i = 0; i < 6; i++) q.push_back(8'($urandom));
        refresh();
        wait_pop(3, "rnd");
        for (int i = 0; i < 6; i++) begin
            p0 = cyc;
            check_frame($sformatf("rnd%0d", i), FRAME);
            if (i < 5) begin
                @(negedge clk);
                chk($sformatf("rnd%0d gap pop", i), fifo_pop, 1);
                chk($sformatf("rnd%0d period", i), cyc - p0, FRAME + 1);
            end
        end
        idle_check(5, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
